// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch stage sitting directly behind the PC register. Samples the current PC,
// issues one outstanding request at a time to a variable-latency instruction
// memory, buffers returned words together with their PCs in a small FIFO and
// hands them to decode over a valid/ready handshake. A redirect (flush) drops
// everything queued and discards the response of any fetch still in flight.
//
// Parameters
//   DATA_WIDTH  width of PC, memory address and instruction word
//   DEPTH       FIFO entries (power of two, >= 2)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   pc           current PC from the PC register
//   pc_en        PC register may advance (high only on request-issue cycles)
//   flush        redirect: drop queue and in-flight fetch
//   imem_req     memory request, held until imem_ack
//   imem_addr    request address, stable while imem_req is high
//   imem_ack     memory response valid for the outstanding request
//   imem_rdata   instruction word returned with imem_ack
//   instr_valid  head entry available to decode
//   instr        head instruction (NOP when !instr_valid)
//   instr_pc     PC of the head instruction (0 when !instr_valid)
//   instr_ready  decode accepts the head this cycle
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_en,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP      = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;

  logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

  logic can_issue;
  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Control strobes
  // ---------------------------------------------------------------------------
  // Issue decision uses the registered count, so a pop in the same cycle only
  // frees a slot for the following IDLE check.
  assign can_issue = (state_q == IDLE) && !flush && (count_q < FULL_CNT);

  // Responses are only kept when they answer a live request; DROP swallows them.
  assign push = (state_q == WAIT) && imem_ack && !flush;

  // instr_valid already excludes flush, so flush also blocks pops.
  assign pop  = instr_valid && instr_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (can_issue) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // The request cannot be withdrawn; wait for its response and drop it.
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en     = 1'b0;
    imem_req  = 1'b0;
    imem_addr = '0;
    unique case (state_q)
      IDLE: begin
        // Held low while reset is asserted so the PC register does not advance.
        pc_en = can_issue && !rst;
      end
      WAIT, DROP: begin
        imem_req  = 1'b1;
        imem_addr = req_pc_q;
      end
      default: begin
        pc_en    = 1'b0;
        imem_req = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request PC capture and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    req_pc_d = req_pc_q;
    if (can_issue) begin
      req_pc_d = pc;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      // Pointers are PTR_W wide and DEPTH is a power of two, so they wrap
      // naturally modulo DEPTH.
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_q <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage carries no reset: contents are qualified by count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side head presentation
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_valid = (count_q != '0) && !flush;
    instr       = NOP;
    instr_pc    = '0;
    if (instr_valid) begin
      instr    = instr_mem[rd_ptr_q];
      instr_pc = pc_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pc = '0;
  logic          pc_en;
  logic          flush = 1'b0;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [DW-1:0] instr_pc;
  logic          instr_ready = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_en      (pc_en),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  // Scoreboard: instructions decode must see, oldest first.
  entry_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int n_spur   = 0;

  // Reference model of the fetch unit, as seen from outside.
  bit          busy     = 1'b0;  // a request is outstanding on the bus
  bit          live     = 1'b0;  // that request has not been cancelled by a flush
  bit          post_rst = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] pc_next  = '0;
  int          lat      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head must match the oldest scoreboard entry.
  always @(negedge clk) begin
    entry_t e;
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_empty: got pc %h instr %h expected no valid head at %0t",
                 instr_pc, instr, $time);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", instr_pc, e.pc);
        chk("pop_instr", instr, e.ins);
        n_pops++;
      end
    end
  end

  // One clock of stimulus plus model update. lat_mode < 0 picks random latency.
  task automatic cycle(input int lat_mode, input int ready_pct, input int flush_pct,
                       input int spur_pct, input bit do_rst, input logic [31:0] rst_pc);
    bit exp_pcen;
    bit exp_valid;
    @(posedge clk);
    #1;
    pc         = pc_next;
    rst        = do_rst;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    if (do_rst) begin
      flush       = 1'b0;
      instr_ready = 1'b0;
    end else begin
      flush       = ($urandom_range(0, 99) < flush_pct);
      instr_ready = ($urandom_range(0, 99) < ready_pct);
      if (busy) begin
        if (lat == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = live ? $urandom : 32'hDEAD_BEEF;
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 99) < spur_pct) begin
        // Protocol error injected on purpose: must be ignored.
        imem_ack = 1'b1;
        n_spur++;
      end
    end
    #1;
    if (do_rst) begin
      sb.delete();
      busy     = 1'b0;
      live     = 1'b0;
      post_rst = 1'b1;
      pc_next  = rst_pc;
      return;
    end
    if (post_rst) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_instr", instr, NOP);
      chk("rst_instr_pc", instr_pc, 0);
      post_rst = 1'b0;
    end
    exp_pcen  = !busy && !flush && (sb.size() < DEPTH);
    exp_valid = (sb.size() != 0) && !flush;
    chk("pc_en", pc_en, exp_pcen);
    chk("imem_req", imem_req, busy);
    if (busy) chk("imem_addr", imem_addr, req_addr);
    chk("instr_valid", instr_valid, exp_valid);
    if (!exp_valid) begin
      chk("empty_instr", instr, NOP);
      chk("empty_instr_pc", instr_pc, 0);
    end
    if (imem_ack && busy) begin
      busy = 1'b0;
      if (live && !flush) sb.push_back({req_addr, imem_rdata});
    end
    if (flush) begin
      sb.delete();
      live = 1'b0;
    end
    if (exp_pcen) begin
      busy     = 1'b1;
      live     = 1'b1;
      req_addr = pc;
      lat      = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end
    if (flush) pc_next = 32'h100 + ($urandom_range(0, 63) << 2);
    else if (exp_pcen) pc_next = pc + 32'd4;
    else pc_next = pc;
  endtask

  task automatic run(input int n, input int lat_mode, input int ready_pct,
                     input int flush_pct, input int spur_pct, input int rst_pct);
    bit r;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(0, 99) < rst_pct);
      cycle(lat_mode, ready_pct, flush_pct, spur_pct, r, {$urandom_range(0, 255), 2'b00});
    end
  endtask

  task automatic reset_dut(input logic [31:0] start_pc);
    cycle(0, 0, 0, 0, 1'b1, start_pc);
  endtask

  initial begin
    reset_dut(32'h0);
    reset_dut(32'h0);
    // Zero-wait memory, decode always ready.
    run(20, 0, 100, 0, 0, 0);
    // Three-cycle request hold.
    reset_dut(32'h10);
    run(20, 2, 100, 0, 0, 0);
    // Fill to full with decode stalled, then drain.
    reset_dut(32'h0);
    run(16, 0, 0, 0, 0, 0);
    run(10, 0, 100, 0, 0, 0);
    // Flush-heavy traffic with variable latency.
    reset_dut(32'h0);
    run(60, -1, 60, 15, 0, 0);
    // Everything random, including spurious acks and mid-run resets.
    reset_dut(32'h0);
    run(3000, -1, 70, 5, 3, 1);
    chk("pops_seen", 32'(n_pops > 100), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
